// File: rtl/gather_pkg.sv
// Shared definitions for the buffer-gather controller: FSM encoding and
// the running-minimum seed value.
package gather_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SCAN = 2'd2,
    ST_DONE = 2'd3
  } gather_state_e;

  localparam logic [31:0] MIN_INIT = 32'hFFFF_FFFF;

  // Unsigned strict-less comparison; a tie never displaces the earlier core.
  function automatic logic beats(input logic [31:0] cand, input logic [31:0] cur);
    beats = (cand < cur);
  endfunction

endpackage

// File: rtl/buf_gather_ctrl.sv
// Waits for every worker buffer to be flagged, then scans the cores one per
// cycle and reports the core with the smallest primary value.
module buf_gather_ctrl
  import gather_pkg::*;
#(
  parameter int NUM_CORES = 61,
  parameter int ADDR_W    = 6,
  parameter int TIMEOUT   = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              all_buf_flags,
  output logic [ADDR_W-1:0] buf_val_1_addr,
  output logic [ADDR_W-1:0] buf_val_2_addr,
  input  logic [31:0]       buf_val_1_select,
  input  logic [31:0]       buf_val_2_select,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [31:0]       best_val,
  output logic [31:0]       best_aux,
  output logic [ADDR_W-1:0] best_idx
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_CORES - 1);

  gather_state_e      state_r, state_next_s;
  logic [WAIT_W-1:0]  wait_cnt_r, wait_cnt_next_s;
  logic [ADDR_W-1:0]  addr_r, addr_next_s;
  logic [31:0]        min_val_r, min_val_next_s;
  logic [31:0]        min_aux_r, min_aux_next_s;
  logic [ADDR_W-1:0]  min_idx_r, min_idx_next_s;
  logic [31:0]        best_val_r, best_val_next_s;
  logic [31:0]        best_aux_r, best_aux_next_s;
  logic [ADDR_W-1:0]  best_idx_r, best_idx_next_s;
  logic               busy_r, busy_next_s;
  logic               done_r, done_next_s;
  logic               timeout_r, timeout_next_s;
  logic               take_s;
  logic [31:0]        cand_val_s, cand_aux_s;
  logic [ADDR_W-1:0]  cand_idx_s;

  // Next-state, counter and result computation.
  always_comb begin
    state_next_s    = state_r;
    wait_cnt_next_s = wait_cnt_r;
    addr_next_s     = {ADDR_W{1'b0}};
    min_val_next_s  = min_val_r;
    min_aux_next_s  = min_aux_r;
    min_idx_next_s  = min_idx_r;
    best_val_next_s = best_val_r;
    best_aux_next_s = best_aux_r;
    best_idx_next_s = best_idx_r;
    done_next_s     = 1'b0;
    timeout_next_s  = 1'b0;

    // Core 0 always seeds the minimum so the winner's aux value is a real
    // sample even when every primary value equals the seed.
    take_s = (addr_r == {ADDR_W{1'b0}}) || beats(buf_val_1_select, min_val_r);
    if (take_s) begin
      cand_val_s = buf_val_1_select;
      cand_aux_s = buf_val_2_select;
      cand_idx_s = addr_r;
    end else begin
      cand_val_s = min_val_r;
      cand_aux_s = min_aux_r;
      cand_idx_s = min_idx_r;
    end

    case (state_r)
      ST_IDLE: begin
        wait_cnt_next_s = {WAIT_W{1'b0}};
        if (start) begin
          state_next_s = ST_WAIT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (all_buf_flags) begin
          state_next_s    = ST_SCAN;
          wait_cnt_next_s = {WAIT_W{1'b0}};
          min_val_next_s  = MIN_INIT;
          min_aux_next_s  = 32'h0000_0000;
          min_idx_next_s  = {ADDR_W{1'b0}};
        end else if (wait_cnt_r == WAIT_LAST) begin
          state_next_s    = ST_IDLE;
          wait_cnt_next_s = {WAIT_W{1'b0}};
          timeout_next_s  = 1'b1;
        end else begin
          wait_cnt_next_s = wait_cnt_r + WAIT_W'(1);
        end
      end
      ST_SCAN: begin
        min_val_next_s = cand_val_s;
        min_aux_next_s = cand_aux_s;
        min_idx_next_s = cand_idx_s;
        if (addr_r == ADDR_LAST) begin
          state_next_s    = ST_DONE;
          done_next_s     = 1'b1;
          best_val_next_s = cand_val_s;
          best_aux_next_s = cand_aux_s;
          best_idx_next_s = cand_idx_s;
        end else begin
          addr_next_s = addr_r + ADDR_W'(1);
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase

    busy_next_s = (state_next_s != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= {WAIT_W{1'b0}};
      addr_r     <= {ADDR_W{1'b0}};
      min_val_r  <= 32'h0000_0000;
      min_aux_r  <= 32'h0000_0000;
      min_idx_r  <= {ADDR_W{1'b0}};
      best_val_r <= 32'h0000_0000;
      best_aux_r <= 32'h0000_0000;
      best_idx_r <= {ADDR_W{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      wait_cnt_r <= wait_cnt_next_s;
      addr_r     <= addr_next_s;
      min_val_r  <= min_val_next_s;
      min_aux_r  <= min_aux_next_s;
      min_idx_r  <= min_idx_next_s;
      best_val_r <= best_val_next_s;
      best_aux_r <= best_aux_next_s;
      best_idx_r <= best_idx_next_s;
      busy_r     <= busy_next_s;
      done_r     <= done_next_s;
      timeout_r  <= timeout_next_s;
    end
  end

  assign buf_val_1_addr = addr_r;
  assign buf_val_2_addr = addr_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign timeout        = timeout_r;
  assign best_val       = best_val_r;
  assign best_aux       = best_aux_r;
  assign best_idx       = best_idx_r;

endmodule

// File: tb/tb_buf_gather_ctrl.sv
// Directed bench for buf_gather_ctrl: table of value patterns with
// hand-computed winners, plus timeout, reset-abort and mid-scan sequences.
module tb_buf_gather_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        all_buf_flags;
  logic [5:0]  buf_val_1_addr;
  logic [5:0]  buf_val_2_addr;
  logic [31:0] buf_val_1_select;
  logic [31:0] buf_val_2_select;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [31:0] best_val;
  logic [31:0] best_aux;
  logic [5:0]  best_idx;

  logic [31:0] v1 [0:63];
  logic [31:0] v2 [0:63];

  int total = 0;
  int bad   = 0;

  assign buf_val_1_select = v1[buf_val_1_addr];
  assign buf_val_2_select = v2[buf_val_2_addr];

  buf_gather_ctrl #(
    .NUM_CORES(61),
    .ADDR_W   (6),
    .TIMEOUT  (10)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .all_buf_flags   (all_buf_flags),
    .buf_val_1_addr  (buf_val_1_addr),
    .buf_val_2_addr  (buf_val_2_addr),
    .buf_val_1_select(buf_val_1_select),
    .buf_val_2_select(buf_val_2_select),
    .busy            (busy),
    .done            (done),
    .timeout         (timeout),
    .best_val        (best_val),
    .best_aux        (best_aux),
    .best_idx        (best_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          pat;
    logic [5:0]  exp_idx;
    logic [31:0] exp_val;
    logic [31:0] exp_aux;
    bit          chk_aux;
  } vec_t;

  vec_t vecs [0:6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Cores 61..63 hold 0 so a scan running past the last core would be caught.
  task automatic fill(input int pat);
    for (int k = 0; k < 64; k++) begin
      v2[k] = 32'hA000_0000 + 32'(3 * k);
      if (k >= 61) begin
        v1[k] = 32'h0000_0000;
      end else begin
        case (pat)
          0: v1[k] = 32'(1000 - k);
          1: v1[k] = (k == 5 || k == 9) ? 32'd7 : 32'd100;
          2: v1[k] = 32'hFFFF_FFFF;
          3: v1[k] = 32'(k + 50);
          4: v1[k] = (k == 0 || k == 60) ? 32'd3 : 32'd9;
          5: v1[k] = (k == 30) ? 32'd0 : 32'd500;
          default: v1[k] = (k == 60) ? 32'h7FFF_FFFF : 32'h8000_0000;
        endcase
      end
    end
  endtask

  // Starts a gather; flags rise flag_at cycles after the start is taken.
  task automatic gather(input int flag_at, input bit drop, input bit restart,
                        output int lat, output bit addr_ok, output bit saw_to);
    int cnt;
    int scan_start;
    addr_ok = 1'b1;
    saw_to  = 1'b0;
    lat     = -1;
    @(negedge clk);
    start = 1'b1;
    all_buf_flags = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    if (flag_at == 0) all_buf_flags = 1'b1;
    scan_start = flag_at + 1;
    while (!done && cnt < 200) begin
      @(negedge clk);
      cnt++;
      if (timeout) saw_to = 1'b1;
      if (cnt >= scan_start && cnt < scan_start + 61) begin
        if (buf_val_1_addr != 6'(cnt - scan_start) || buf_val_2_addr != 6'(cnt - scan_start))
          addr_ok = 1'b0;
      end else if (buf_val_1_addr != 6'd0 || buf_val_2_addr != 6'd0) begin
        addr_ok = 1'b0;
      end
      if (cnt == flag_at) all_buf_flags = 1'b1;
      if (drop && cnt == scan_start + 20) all_buf_flags = 1'b0;
      start = (restart && cnt == scan_start + 25);
    end
    if (done) lat = cnt;
    start = 1'b0;
    all_buf_flags = 1'b0;
  endtask

  initial begin
    int lat;
    int cnt;
    bit addr_ok;
    bit saw_to;
    bit seen;
    vec_t v;

    vecs[0] = '{0, 6'd60, 32'd940,        32'hA000_00B4, 1'b1};
    vecs[1] = '{1, 6'd5,  32'd7,          32'hA000_000F, 1'b1};
    vecs[2] = '{2, 6'd0,  32'hFFFF_FFFF,  32'h0,         1'b0};
    vecs[3] = '{3, 6'd0,  32'd50,         32'hA000_0000, 1'b1};
    vecs[4] = '{4, 6'd0,  32'd3,          32'hA000_0000, 1'b1};
    vecs[5] = '{5, 6'd30, 32'd0,          32'hA000_005A, 1'b1};
    vecs[6] = '{6, 6'd60, 32'h7FFF_FFFF,  32'hA000_00B4, 1'b1};

    rst_n = 1'b0;
    start = 1'b0;
    all_buf_flags = 1'b0;
    fill(0);
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_best_val", best_val, 32'd0);
    chk("rst_best_idx", {26'd0, best_idx}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      v = vecs[i];
      fill(v.pat);
      gather(0, 1'b0, 1'b0, lat, addr_ok, saw_to);
      chk($sformatf("p%0d_latency", v.pat), 32'(lat), 32'd62);
      chk($sformatf("p%0d_addr_seq", v.pat), {31'd0, addr_ok}, 32'd1);
      chk($sformatf("p%0d_best_idx", v.pat), {26'd0, best_idx}, {26'd0, v.exp_idx});
      chk($sformatf("p%0d_best_val", v.pat), best_val, v.exp_val);
      if (v.chk_aux) chk($sformatf("p%0d_best_aux", v.pat), best_aux, v.exp_aux);
      @(negedge clk);
      chk($sformatf("p%0d_done_width", v.pat), {31'd0, done}, 32'd0);
      chk($sformatf("p%0d_idle_busy", v.pat), {31'd0, busy}, 32'd0);
    end

    // Timeout with flags low: best_* still holds pattern 6 result.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    seen = 1'b0;
    while (!timeout && cnt < 50) begin
      @(negedge clk);
      cnt++;
      if (done) seen = 1'b1;
    end
    chk("to_latency", 32'(cnt), 32'd10);
    chk("to_no_done", {31'd0, seen}, 32'd0);
    chk("to_best_val_held", best_val, 32'h7FFF_FFFF);
    chk("to_best_idx_held", {26'd0, best_idx}, 32'd60);
    @(negedge clk);
    chk("to_pulse_width", {31'd0, timeout}, 32'd0);
    chk("to_idle_busy", {31'd0, busy}, 32'd0);

    // Flags arriving in the final WAIT cycle win over timeout.
    fill(1);
    gather(9, 1'b0, 1'b0, lat, addr_ok, saw_to);
    chk("edge_no_timeout", {31'd0, saw_to}, 32'd0);
    chk("edge_latency", 32'(lat), 32'd71);
    chk("edge_addr_seq", {31'd0, addr_ok}, 32'd1);
    chk("edge_best_idx", {26'd0, best_idx}, 32'd5);

    // Flags drop and start re-pulses mid-scan: one done, full-length scan.
    fill(0);
    gather(0, 1'b1, 1'b1, lat, addr_ok, saw_to);
    chk("mid_latency", 32'(lat), 32'd62);
    chk("mid_addr_seq", {31'd0, addr_ok}, 32'd1);
    chk("mid_best_val", best_val, 32'd940);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    chk("mid_no_second_gather", {31'd0, seen}, 32'd0);

    // Asynchronous reset while scanning address 30.
    fill(3);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    all_buf_flags = 1'b1;
    repeat (31) @(negedge clk);
    chk("rs_addr_before", {26'd0, buf_val_1_addr}, 32'd30);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_busy", {31'd0, busy}, 32'd0);
    chk("rs_flags", {29'd0, done, timeout, 1'b0}, 32'd0);
    chk("rs_addr", {20'd0, buf_val_1_addr, buf_val_2_addr}, 32'd0);
    chk("rs_best_val", best_val, 32'd0);
    chk("rs_best_aux", best_aux, 32'd0);
    chk("rs_best_idx", {26'd0, best_idx}, 32'd0);
    all_buf_flags = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done || timeout || busy) seen = 1'b1;
    end
    chk("rs_stays_idle", {31'd0, seen}, 32'd0);
    fill(0);
    gather(0, 1'b0, 1'b0, lat, addr_ok, saw_to);
    chk("rs_regather_latency", 32'(lat), 32'd62);
    chk("rs_regather_idx", {26'd0, best_idx}, 32'd60);
    chk("rs_regather_val", best_val, 32'd940);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
